// File: rtl/adc_scheduler.sv
// MMIO conversion sequencer for the serial ADC: start pulses, conversion tracking, sample FIFO.
// Optional watchdog on stuck conversions is compiled in with `define ADC_SCHED_TIMEOUT_EN.
module adc_scheduler #(
    parameter logic [15:0] BASE_ADDR      = 16'h8010,
    parameter int          FIFO_DEPTH     = 8,
    parameter logic [4:0]  ADC_IDLE_STATE = 5'd0,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic [15:0] address,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        adc_start,
    input  logic [4:0]  adc_state,
    input  logic [9:0]  sample,
    output logic        busy,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_CAPTURE   = 3'd4;
    localparam logic [2:0] S_HOLD      = 3'd5;

    logic [2:0]    state, state_next;
    logic          ctrl_en, ctrl_cont, ctrl_irq_en, trig_q;
    logic [15:0]   period, pcnt;
    logic          overrun, timeout;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;

    logic [15:0] offset;
    logic        hit, wr_ctrl, wr_period, wr_status, rd_pop;
    logic        empty, full, pop, capture, flush, push_ok, period_hit, tmo;

    assign offset    = address - BASE_ADDR;
    assign hit       = offset < 16'd4;
    assign wr_ctrl   = write_enable & hit & (offset[1:0] == 2'd0);
    assign wr_period = write_enable & hit & (offset[1:0] == 2'd1);
    assign wr_status = write_enable & hit & (offset[1:0] == 2'd2);
    assign rd_pop    = read_enable  & hit & (offset[1:0] == 2'd3);

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop     = rd_pop & ~empty;
    assign capture = (state == S_CAPTURE);
    assign flush   = wr_ctrl & write_data[3];
    // a same-cycle pop frees the slot the capture needs
    assign push_ok = capture & (~full | pop);

    // PERIOD of 0 or 1 always counts as expired
    assign period_hit = ({1'b0, pcnt} + 17'd1) >= {1'b0, period};

    assign adc_start = (state == S_START);
    assign busy      = (state == S_START) | (state == S_WAIT_BUSY) |
                       (state == S_WAIT_DONE) | (state == S_CAPTURE);
    assign irq       = ctrl_irq_en & ~empty;

`ifdef ADC_SCHED_TIMEOUT_EN
    logic [15:0] wdog;
    logic        waiting;

    assign waiting = (state == S_WAIT_BUSY) | (state == S_WAIT_DONE);
    assign tmo     = waiting & (({1'b0, wdog} + 17'd1) >= {1'b0, TIMEOUT_CYCLES});

    always_ff @(posedge clock) begin
        if (!reset)       wdog <= '0;
        else if (waiting) wdog <= wdog + 16'd1;
        else              wdog <= '0;
    end
`else
    // no watchdog: the limit is referenced only to keep it visible, never fires
    assign tmo = 1'b0 & (TIMEOUT_CYCLES == 16'd0);
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (ctrl_en & (trig_q | ctrl_cont)) state_next = S_START;
            S_START:     state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: if (tmo) state_next = S_IDLE;
                         else if (adc_state != ADC_IDLE_STATE) state_next = S_WAIT_DONE;
            S_WAIT_DONE: if (tmo) state_next = S_IDLE;
                         else if (adc_state == ADC_IDLE_STATE) state_next = S_CAPTURE;
            S_CAPTURE:   if (ctrl_en & ctrl_cont) state_next = period_hit ? S_START : S_HOLD;
                         else state_next = S_IDLE;
            S_HOLD:      if (!(ctrl_en & ctrl_cont)) state_next = S_IDLE;
                         else if (period_hit) state_next = S_START;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_IDLE;
            ctrl_en     <= 1'b0;
            ctrl_cont   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            trig_q      <= 1'b0;
            period      <= '0;
            pcnt        <= '0;
            overrun     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state  <= state_next;
            trig_q <= wr_ctrl & write_data[2];
            if (wr_ctrl) begin
                ctrl_en     <= write_data[0];
                ctrl_cont   <= write_data[1];
                ctrl_irq_en <= write_data[4];
            end
            if (tmo) ctrl_cont <= 1'b0;
            if (wr_period) period <= write_data;

            if (state_next == S_START) pcnt <= '0;
            else if (pcnt != 16'hFFFF) pcnt <= pcnt + 16'd1;

            if (wr_status & write_data[7]) overrun <= 1'b0;
            if (capture & full & ~pop & ~flush) overrun <= 1'b1;
            if (wr_status & write_data[9]) timeout <= 1'b0;
            if (tmo) timeout <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (pop)     rptr <= rptr + 1'b1;
            if (push_ok) wptr <= wptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok & ~flush) mem[wptr] <= sample;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            read_data <= '0;
        end else if (read_enable & hit) begin
            case (offset[1:0])
                2'd0:    read_data <= {11'b0, ctrl_irq_en, 2'b0, ctrl_cont, ctrl_en};
                2'd1:    read_data <= period;
                2'd2:    read_data <= {6'b0, timeout, busy, overrun, full, empty, 5'(count)};
                default: read_data <= empty ? 16'h0000 : {6'b0, mem[rptr]};
            endcase
        end else begin
            read_data <= '0;
        end
    end

endmodule

// File: doc/adc_scheduler.md
Name: adc_scheduler

Overview:
MMIO-mapped sequencer for the serial ADC peripheral. It issues conversion-start pulses, either single-shot or periodic at a programmable interval, and tracks each conversion through the ADC state output. Finished samples go into a small FIFO that the NBBPU drains over the data-memory bus. It replaces the direct write-to-reset ADC hookup in the SoC top level.

Parameters:
BASE_ADDR, 16'h8010, base of the 4-word register window
FIFO_DEPTH, 8, sample FIFO entries (power of 2, 2..16)
ADC_IDLE_STATE, 5'd0, adc_state value meaning ADC idle/conversion complete
TIMEOUT_CYCLES, 16'd4096, watchdog limit per conversion (only with ADC_SCHED_TIMEOUT_EN)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
write_enable  in  1  CPU data write strobe
read_enable  in  1  CPU data read strobe
address  in  16  CPU data address
write_data  in  16  CPU write data
read_data  out  16  register read data; 0 when address not in window
adc_start  out  1  one-cycle pulse to the ADC reset/start input
adc_state  in  5  ADC FSM state
sample  in  10  ADC conversion result
busy  out  1  high while a conversion is in flight
irq  out  1  CTRL.irq_en & FIFO not empty

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-low on `reset`. The reset pin is sampled on the rising edge of clock; it is active when low.
- Reset values: read_data=0, adc_start=0, busy=0, irq=0, CTRL=0, PERIOD=0, FIFO empty, sticky flags=0, FSM=IDLE.
- Register map (word offsets from BASE_ADDR):
  - +0 CTRL (RW):
    - [0] enable
    - [1] continuous
    - [2] trigger (write-1, self-clears, reads 0)
    - [3] flush (write-1, self-clears, reads 0)
    - [4] irq_en
  - +1 PERIOD (RW, 16b): clock cycles from one start pulse to the next.
  - +2 STATUS (RO fields; W1C sticky bits):
    - [4:0] FIFO count
    - [5] empty
    - [6] full
    - [7] overrun (sticky)
    - [8] busy
    - [9] timeout (sticky)
    - Writing 1 to [7] or [9] clears that bit.
  - +3 DATA (RO): {6'b0, oldest sample}. A read pops the FIFO. A read when empty returns 0 and does not pop.
- Read latency: read_data is registered and valid 1 cycle after read_enable, matching RAM timing. A read without a matching address drives 0.
- Writes to RO fields are ignored.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, CAPTURE, HOLD.
  - IDLE: go to START when (enable & trigger) or (enable & continuous).
  - START: adc_start=1 for exactly one cycle; reload period counter to 0; go to WAIT_BUSY.
  - WAIT_BUSY: wait for adc_state != ADC_IDLE_STATE, then go to WAIT_DONE.
  - WAIT_DONE: wait for adc_state == ADC_IDLE_STATE, then go to CAPTURE.
  - CAPTURE: push sample into the FIFO (one cycle). If continuous & enable, go to HOLD; otherwise go to IDLE.
  - HOLD: when period counter >= PERIOD-1, go to START. PERIOD of 0 or 1, or PERIOD shorter than the conversion, gives a back-to-back restart straight from CAPTURE.
- busy = 1 in START, WAIT_BUSY, WAIT_DONE and CAPTURE.
- The period counter is 16 bits, increments every cycle from START onward, and saturates at 16'hFFFF.
- Trigger while busy: ignored, not queued.
- Clearing enable mid-conversion: the current conversion completes and is captured, then the FSM goes to IDLE. HOLD exits to IDLE immediately.
- FIFO full at CAPTURE: the new sample is dropped and overrun is set. If a DATA pop and CAPTURE happen in the same cycle on a full FIFO, the pop wins first, the push succeeds, there is no overrun, and count is unchanged.
- Flush: empties the FIFO in one cycle and leaves sticky flags untouched. If flush and CAPTURE coincide, the FIFO ends empty.
- Pointers wrap modulo FIFO_DEPTH. Count is held in a separate register of width log2(FIFO_DEPTH)+1.
- Reset mid-operation: all state returns to reset values in the same clock edge, and adc_start drops the following cycle.

Optional Feature:
ADC_SCHED_TIMEOUT_EN.
- Defined: a watchdog counts cycles spent in WAIT_BUSY plus WAIT_DONE. On reaching TIMEOUT_CYCLES it sets the timeout sticky bit, pushes nothing and returns to IDLE, clearing continuous.
- Not defined: the FSM waits indefinitely, STATUS[9] reads 0, and the TIMEOUT_CYCLES parameter is unused.

Test Plan:
- Single shot: write CTRL=0x5, ADC model idles 3 cycles then returns sample 10'h2A5. Expect adc_start high for exactly 1 cycle, busy for the conversion, then STATUS count=1/empty=0, and DATA read returns 16'h02A5 one cycle after read_enable; count=0 afterwards.
- Periodic: PERIOD=100, CTRL=0x3, conversion 40 cycles. Expect adc_start pulses exactly 100 cycles apart over 5 conversions; with PERIOD=10, expect the restart the cycle after CAPTURE.
- Overrun: continuous with no reads, FIFO_DEPTH=8. After 9 captures expect count=8, full=1, overrun=1, and DATA returning the first 8 samples in order. Writing STATUS=0x80 clears overrun.
- Simultaneous pop+push on a full FIFO: count stays 8, no overrun, and the oldest sample is returned.
- Reset pulled low during WAIT_DONE: all outputs return to reset values next cycle and the FIFO is empty; after release, a trigger works normally.
- With ADC_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=64, ADC stuck non-idle: timeout=1 after 64 cycles, FSM back in IDLE, no push. Without the macro: busy stays high.
